counter_sweep_ctrl: RTL and testbench

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_ctrl_pkg.sv | 15 +
 rtl/counter_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the sweep controller and the up/down counter it drives.
// Holds the FSM state encoding and the default counter width.
package counter_sweep_ctrl_pkg;

    localparam int CNT_WIDTH_DEF = 3;
    localparam int SWP_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sweep_ctrl.sv
// Drives an external up/down loadable counter through num_sweeps
// lo->hi->lo round trips, reversing one count early so the counter turns exactly at the bound.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int SWP_WIDTH = SWP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] lo,
    input  logic [CNT_WIDTH-1:0] hi,
    input  logic [SWP_WIDTH-1:0] num_sweeps,
    input  logic [CNT_WIDTH-1:0] counter_out,
    output logic                 load_en,
    output logic [CNT_WIDTH-1:0] counter_in,
    output logic                 up_down,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [SWP_WIDTH-1:0] sweep_count
);

    state_e               state_q, state_d;
    logic                 load_en_q, load_en_d;
    logic [CNT_WIDTH-1:0] counter_in_q, counter_in_d;
    logic                 up_down_q, up_down_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [SWP_WIDTH-1:0] sweep_count_q, sweep_count_d;
    logic [CNT_WIDTH-1:0] lo_q, lo_d;
    logic [CNT_WIDTH-1:0] hi_q, hi_d;
    logic [SWP_WIDTH-1:0] num_q, num_d;

    logic [CNT_WIDTH-1:0] hi_turn;
    logic [CNT_WIDTH-1:0] lo_turn;
    logic [SWP_WIDTH-1:0] sweep_inc;

    // Counter output is one edge behind, so reverse when it sits one step short of the bound.
    assign hi_turn   = hi_q - CNT_WIDTH'(1);
    assign lo_turn   = lo_q + CNT_WIDTH'(1);
    assign sweep_inc = sweep_count_q + SWP_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        load_en_d     = 1'b0;
        counter_in_d  = counter_in_q;
        up_down_d     = up_down_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        sweep_count_d = sweep_count_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        num_d         = num_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (lo < hi && num_sweeps != '0) begin
                        lo_d          = lo;
                        hi_d          = hi;
                        num_d         = num_sweeps;
                        load_en_d     = 1'b1;
                        counter_in_d  = lo;
                        up_down_d     = 1'b1;
                        busy_d        = 1'b1;
                        sweep_count_d = '0;
                        state_d       = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = UP;
                end
            end
            UP: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (counter_out == hi_turn) begin
                    up_down_d = 1'b0;
                    state_d   = DOWN;
                end
            end
            DOWN: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (counter_out == lo_turn) begin
                    sweep_count_d = sweep_inc;
                    if (sweep_inc == num_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        up_down_d = 1'b1;
                        state_d   = UP;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            load_en_q     <= 1'b0;
            counter_in_q  <= '0;
            up_down_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            sweep_count_q <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            num_q         <= '0;
        end else begin
            state_q       <= state_d;
            load_en_q     <= load_en_d;
            counter_in_q  <= counter_in_d;
            up_down_q     <= up_down_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            sweep_count_q <= sweep_count_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            num_q         <= num_d;
        end
    end

    assign load_en     = load_en_q;
    assign counter_in  = counter_in_q;
    assign up_down     = up_down_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl wired to a loadable up/down counter, 3-bit.
// Expected counter trajectories are generated from the sweep rules as plain lists.
module tb_counter_sweep_ctrl;

    localparam int CW = 3;
    localparam int SW = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    logic [SW-1:0] num_sweeps;
    logic [CW-1:0] counter_out;
    logic          load_en;
    logic [CW-1:0] counter_in;
    logic          up_down;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] sweep_count;

    int errors = 0;
    int checks = 0;

    counter_sweep_ctrl #(.CNT_WIDTH(CW), .SWP_WIDTH(SW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .stop(stop),
        .lo(lo),
        .hi(hi),
        .num_sweeps(num_sweeps),
        .counter_out(counter_out),
        .load_en(load_en),
        .counter_in(counter_in),
        .up_down(up_down),
        .busy(busy),
        .done(done),
        .err(err),
        .sweep_count(sweep_count)
    );

    // Downstream loadable up/down counter: never holds, wraps modulo 8.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            counter_out <= '0;
        else if (load_en)
            counter_out <= counter_in;
        else if (up_down)
            counter_out <= counter_out + CW'(1);
        else
            counter_out <= counter_out - CW'(1);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input int lo_i, input int hi_i, input int n_i,
                          input bit poke);
        int traj[$];
        int last;
        traj = {};
        traj.push_back(lo_i);
        for (int s = 0; s < n_i; s++) begin
            for (int v = lo_i + 1; v <= hi_i; v++) traj.push_back(v);
            for (int v = hi_i - 1; v >= lo_i; v--) traj.push_back(v);
        end
        last = traj.size() - 1;
        start      = 1'b1;
        lo         = CW'(lo_i);
        hi         = CW'(hi_i);
        num_sweeps = SW'(n_i);
        tick();
        start = 1'b0;
        chk("acc_load_en", load_en, 1);
        chk("acc_counter_in", counter_in, lo_i);
        chk("acc_up_down", up_down, 1);
        chk("acc_busy", busy, 1);
        chk("acc_sweep_count", sweep_count, 0);
        for (int k = 0; k <= last; k++) begin
            if (poke && k == 1) begin
                start      = 1'b1;
                lo         = CW'(7);
                hi         = CW'(0);
                num_sweeps = SW'(1);
            end
            if (poke && k == 2) start = 1'b0;
            tick();
            chk("traj_counter", counter_out, traj[k]);
            chk("traj_done", done, (k == last) ? 1 : 0);
            chk("traj_busy", busy, (k == last) ? 0 : 1);
            chk("traj_load_en", load_en, 0);
            chk("traj_err", err, 0);
        end
        start = 1'b0;
        chk("end_sweep_count", sweep_count, n_i);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic do_reject(input int lo_i, input int hi_i, input int n_i);
        start      = 1'b1;
        lo         = CW'(lo_i);
        hi         = CW'(hi_i);
        num_sweeps = SW'(n_i);
        tick();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_load_en", load_en, 0);
        tick();
        chk("rej_err_pulse", err, 0);
        chk("rej_busy2", busy, 0);
    endtask

    initial begin
        int rl;
        int rh;
        int rn;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        lo         = '0;
        hi         = '0;
        num_sweeps = '0;
        #2;
        chk("rst_load_en", load_en, 0);
        chk("rst_counter_in", counter_in, 0);
        chk("rst_up_down", up_down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sweep_count", sweep_count, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        do_job(2, 5, 1, 1'b0);
        do_job(0, 7, 2, 1'b0);
        do_job(3, 4, 3, 1'b0);
        do_job(1, 3, 2, 1'b1);

        do_reject(5, 5, 1);
        do_reject(2, 6, 0);
        do_reject(6, 1, 2);

        // start and stop together in IDLE
        start      = 1'b1;
        stop       = 1'b1;
        lo         = CW'(1);
        hi         = CW'(4);
        num_sweeps = SW'(1);
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_err", err, 0);
        chk("ss_busy", busy, 0);
        chk("ss_load_en", load_en, 0);

        // stop sampled at E0+4
        start      = 1'b1;
        lo         = CW'(1);
        hi         = CW'(6);
        num_sweeps = SW'(1);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("stop_busy_before", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_load_en", load_en, 0);
        chk("stop_sweep_count", sweep_count, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("stop_no_done", done, 0);
            chk("stop_idle_busy", busy, 0);
        end

        // reset while in DOWN of a 0..7 job
        start      = 1'b1;
        lo         = CW'(0);
        hi         = CW'(7);
        num_sweeps = SW'(2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_up_down", up_down, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_load_en", load_en, 0);
        chk("mid_rst_counter_in", counter_in, 0);
        chk("mid_rst_up_down", up_down, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_sweep_count", sweep_count, 0);
        tick();
        chk("rst_held_done", done, 0);
        reset_n = 1'b1;
        tick();
        do_job(2, 5, 1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            rl = int'($urandom_range(0, 6));
            rh = int'($urandom_range(rl + 1, 7));
            rn = int'($urandom_range(1, 3));
            do_job(rl, rh, rn, j[0]);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
